// File: rtl/pe_dispatch.sv
// Operand queue and job sequencer for a floating-point PE computing A*B and C-A*B.
// Runs one job at a time. Each result is held on the output until it is accepted.
module pe_dispatch #(
  parameter int PRECISION  = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 40
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [PRECISION-1:0]          in_a,
  input  logic [PRECISION-1:0]          in_b,
  input  logic [PRECISION-1:0]          in_c,
  output logic [PRECISION-1:0]          pe_a,
  output logic [PRECISION-1:0]          pe_b,
  output logic [PRECISION-1:0]          pe_c,
  output logic                          pe_begin,
  input  logic [PRECISION-1:0]          pe_mult_result,
  input  logic [PRECISION-1:0]          pe_add_result,
  input  logic                          pe_mult_ready,
  input  logic                          pe_add_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [PRECISION-1:0]          out_mult,
  output logic [PRECISION-1:0]          out_sub,
  output logic [3:0]                    out_tag,
  output logic                          out_err,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          err_sticky
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int EW = 3 * PRECISION;
  localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_WAIT_MULT = 3'd2;
  localparam logic [2:0] S_WAIT_ADD  = 3'd3;
  localparam logic [2:0] S_HOLD      = 3'd4;

  logic [2:0]    state;
  logic [TW-1:0] timer;
  logic [3:0]    job_tag;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [EW-1:0] head;
  logic          push;
  logic          pop;

  // Readiness depends on the occupancy register only, never on the pop path.
  assign in_ready = (fifo_count < DEPTH_C);
  assign push     = in_valid && in_ready;
  assign pop      = (state == S_IDLE) && (fifo_count != '0);
  assign head     = mem[rd_ptr];
  assign pe_begin = (state == S_ISSUE);
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_a, in_b, in_c};
    end
  end

  // Power-of-two depth lets both pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      timer      <= '0;
      job_tag    <= '0;
      pe_a       <= '0;
      pe_b       <= '0;
      pe_c       <= '0;
      out_valid  <= 1'b0;
      out_mult   <= '0;
      out_sub    <= '0;
      out_tag    <= '0;
      out_err    <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            pe_a    <= head[EW-1 -: PRECISION];
            pe_b    <= head[2*PRECISION-1 -: PRECISION];
            pe_c    <= head[PRECISION-1:0];
            out_tag <= job_tag;
            timer   <= '0;
            state   <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          state <= S_WAIT_MULT;
        end

        // An early add_ready means the PE already finished both results.
        S_WAIT_MULT: begin
          timer <= timer + TW'(1);
          if (pe_add_ready) begin
            out_mult  <= pe_mult_result;
            out_sub   <= pe_add_result;
            out_err   <= 1'b0;
            out_valid <= 1'b1;
            state     <= S_HOLD;
          end else if (timer == TIMER_LAST) begin
            out_mult   <= pe_mult_ready ? pe_mult_result : '0;
            out_sub    <= '0;
            out_err    <= 1'b1;
            err_sticky <= 1'b1;
            out_valid  <= 1'b1;
            state      <= S_HOLD;
          end else if (pe_mult_ready) begin
            out_mult <= pe_mult_result;
            state    <= S_WAIT_ADD;
          end
        end

        S_WAIT_ADD: begin
          timer <= timer + TW'(1);
          if (pe_add_ready) begin
            out_sub   <= pe_add_result;
            out_err   <= 1'b0;
            out_valid <= 1'b1;
            state     <= S_HOLD;
          end else if (timer == TIMER_LAST) begin
            out_sub    <= '0;
            out_err    <= 1'b1;
            err_sticky <= 1'b1;
            out_valid  <= 1'b1;
            state      <= S_HOLD;
          end
        end

        S_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            job_tag   <= job_tag + 4'd1;
            state     <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_dispatch.sv
// Scoreboard bench for pe_dispatch with a behavioural floating-point PE model.
// Each accepted triple queues its expected result, and a monitor retires the results in order.
module tb_pe_dispatch;

  localparam int PREC  = 32;
  localparam int DEPTH = 4;
  localparam int TMO   = 40;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [PREC-1:0] in_a, in_b, in_c;
  logic [PREC-1:0] pe_a, pe_b, pe_c;
  logic            pe_begin;
  logic [PREC-1:0] pe_mult_result, pe_add_result;
  logic            pe_mult_ready, pe_add_ready;
  logic            out_valid;
  logic            out_ready;
  logic [PREC-1:0] out_mult, out_sub;
  logic [3:0]      out_tag;
  logic            out_err;
  logic            busy;
  logic [2:0]      fifo_count;
  logic            err_sticky;

  pe_dispatch #(.PRECISION(PREC), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .pe_a(pe_a), .pe_b(pe_b), .pe_c(pe_c), .pe_begin(pe_begin),
    .pe_mult_result(pe_mult_result), .pe_add_result(pe_add_result),
    .pe_mult_ready(pe_mult_ready), .pe_add_ready(pe_add_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mult(out_mult), .out_sub(out_sub), .out_tag(out_tag), .out_err(out_err),
    .busy(busy), .fifo_count(fifo_count), .err_sticky(err_sticky)
  );

  typedef struct {
    logic [31:0] a, b, c, mult, sub;
    logic [3:0]  tag;
    logic        err;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   mode_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;
  int   accept_idx = 0;
  int   accept_cycle = 0;
  int   begin_count = 0;
  int   rise_count = 0;
  int   begin_cycle = 0;
  int   rise_cycle = 0;
  int   model_count = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle <= cycle + 1;

  // Occupancy model: accept when not full, pop whenever the dispatcher is idle with work.
  always @(posedge clk) begin
    if (rst) model_count <= 0;
    else model_count <= model_count + ((in_valid && model_count < DEPTH) ? 1 : 0)
                                    - ((!busy && model_count > 0) ? 1 : 0);
  end

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic real sp2r(input logic [31:0] s);
    logic [10:0] e;
    if (s[30:0] == 31'h0) return 0.0;
    e = {3'b000, s[30:23]} + 11'd896;
    return $bitstoreal({s[31], e, s[22:0], 29'h0});
  endfunction

  function automatic logic [31:0] randOperand();
    int v;
    v = int'($urandom_range(2000)) - 1000;
    return r2sp(real'(v));
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one triple and hold it until taken; the expected result is queued at acceptance.
  // Modes: 0 nominal PE, 1 silent PE, 2 early add_ready, 3 slow add_ready.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input int mode);
    exp_t e;
    real  ra, rb, rc;
    logic ok;
    int   guard;
    guard = 0;
    in_a = a; in_b = b; in_c = c; in_valid = 1'b1;
    while (1) begin
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      guard++;
      if (guard > 500) begin
        checks++; errors++;
        $display("[TB] FAIL accept_timeout: got no acceptance, expected acceptance within 500 cycles");
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    accept_cycle = cycle;
    ra = sp2r(a); rb = sp2r(b); rc = sp2r(c);
    e.a = a; e.b = b; e.c = c;
    e.tag = 4'(accept_idx);
    e.err = (mode == 1);
    e.mult = (mode == 1) ? 32'h0 : r2sp(ra * rb);
    e.sub  = (mode == 1) ? 32'h0 : r2sp(rc - ra * rb);
    e.lat  = (mode == 1) ? TMO + 1 : (mode == 2) ? 6 : (mode == 3) ? 36 : 26;
    exp_q.push_back(e);
    mode_q.push_back(mode);
    accept_idx++;
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      waitCycles(1);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("[TB] FAIL drain_timeout: got %0d results outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    mode_q.delete();
    accept_idx = 0;
    rst = 1'b0;
  endtask

  task automatic checkResetState();
    checkOutput("rst_fifo_count", 32'(fifo_count), 32'd0);
    checkOutput("rst_in_ready",   32'(in_ready),   32'd1);
    checkOutput("rst_busy",       32'(busy),       32'd0);
    checkOutput("rst_pe_begin",   32'(pe_begin),   32'd0);
    checkOutput("rst_pe_a",       pe_a,            32'd0);
    checkOutput("rst_pe_b",       pe_b,            32'd0);
    checkOutput("rst_pe_c",       pe_c,            32'd0);
    checkOutput("rst_out_valid",  32'(out_valid),  32'd0);
    checkOutput("rst_out_mult",   out_mult,        32'd0);
    checkOutput("rst_out_sub",    out_sub,         32'd0);
    checkOutput("rst_out_tag",    32'(out_tag),    32'd0);
    checkOutput("rst_out_err",    32'(out_err),    32'd0);
    checkOutput("rst_err_sticky", 32'(err_sticky), 32'd0);
  endtask

  // PE model: real-valued A*B and C-A*B, each ready pulsed for one cycle at a mode-dependent delay.
  initial begin
    int          pe_cnt;
    int          pe_mode;
    logic [31:0] op_a, op_b, op_c;
    real         ra, rb, rc;
    pe_cnt = 100000; pe_mode = 0; op_a = 0; op_b = 0; op_c = 0;
    pe_mult_ready = 1'b0; pe_add_ready = 1'b0;
    pe_mult_result = 32'h0; pe_add_result = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      pe_mult_ready = 1'b0;
      pe_add_ready = 1'b0;
      pe_mult_result = $urandom;
      pe_add_result = $urandom;
      if (pe_begin) begin
        pe_cnt = 0;
        op_a = pe_a; op_b = pe_b; op_c = pe_c;
        pe_mode = (mode_q.size() != 0) ? mode_q.pop_front() : 0;
      end else if (pe_cnt < 100000) begin
        pe_cnt++;
      end
      ra = sp2r(op_a); rb = sp2r(op_b); rc = sp2r(op_c);
      if ((pe_mode == 0 || pe_mode == 3) && pe_cnt == 10) begin
        pe_mult_ready = 1'b1;
        pe_mult_result = r2sp(ra * rb);
      end
      if ((pe_mode == 0 && pe_cnt == 25) || (pe_mode == 3 && pe_cnt == 35) || (pe_mode == 2 && pe_cnt == 5)) begin
        pe_add_ready = 1'b1;
        pe_add_result = r2sp(rc - ra * rb);
        if (pe_mode == 2) begin
          pe_mult_ready = 1'b1;
          pe_mult_result = r2sp(ra * rb);
        end
      end
    end
  end

  // Monitor: occupancy, pe_begin shape, and in-order retirement against the scoreboard.
  initial begin
    logic prev_begin, prev_valid;
    exp_t e;
    prev_begin = 1'b0;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_begin = 1'b0;
        prev_valid = 1'b0;
        continue;
      end
      checkOutput("fifo_count", 32'(fifo_count), 32'(model_count));
      checkOutput("in_ready", 32'(in_ready), 32'(model_count < DEPTH));
      if (pe_begin) begin
        checkOutput("begin_pulse", 32'({prev_begin, out_valid}), 32'd0);
        begin_count++;
        begin_cycle = cycle;
      end
      if (out_valid && !prev_valid) begin
        rise_count++;
        rise_cycle = cycle;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_out_valid: got out_valid=1, expected 0 (no job outstanding)");
        end
      end
      if (out_valid && out_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checkOutput("out_mult", out_mult, e.mult);
        checkOutput("out_sub", out_sub, e.sub);
        checkOutput("out_tag", 32'(out_tag), 32'(e.tag));
        checkOutput("out_err", 32'(out_err), 32'(e.err));
        checkOutput("pe_a_stable", pe_a, e.a);
        checkOutput("pe_b_stable", pe_b, e.b);
        checkOutput("pe_c_stable", pe_c, e.c);
        checkOutput("latency", 32'(rise_cycle - begin_cycle), 32'(e.lat));
      end
      prev_begin = pe_begin;
      prev_valid = out_valid;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n, snap_rise, snap_begin;
    logic [31:0] c2, c3, c10;
    rst = 1'b1; in_valid = 1'b0; in_a = 0; in_b = 0; in_c = 0; out_ready = 1'b0;
    c2 = 32'h40000000; c3 = 32'h40400000; c10 = 32'h41200000;

    $display("[TB] reset and single directed job");
    doReset();
    checkResetState();
    begin_count = 0;
    applyStimulus(c2, c3, c10, 0);
    n = 0;
    while (!out_valid && n < 80) begin waitCycles(1); n++; end
    checkOutput("single_mult", out_mult, 32'h40C00000);
    checkOutput("single_sub", out_sub, 32'h40800000);
    checkOutput("single_tag", 32'(out_tag), 32'd0);
    checkOutput("single_err", 32'(out_err), 32'd0);
    checkOutput("single_begin_latency", 32'(begin_cycle - accept_cycle), 32'd1);
    waitCycles(5);
    checkOutput("single_hold_valid", 32'(out_valid), 32'd1);
    checkOutput("single_begin_count", 32'(begin_count), 32'd1);
    out_ready = 1'b1;
    waitDrain(50);

    $display("[TB] backpressure with out_ready low");
    doReset();
    out_ready = 1'b0;
    begin_count = 0;
    for (int i = 0; i < 5; i++) applyStimulus(randOperand(), randOperand(), randOperand(), 0);
    checkOutput("bp_in_ready_low", 32'(in_ready), 32'd0);
    waitCycles(60);
    checkOutput("bp_single_begin", 32'(begin_count), 32'd1);
    out_ready = 1'b1;
    applyStimulus(randOperand(), randOperand(), randOperand(), 0);
    waitDrain(400);
    checkOutput("bp_begin_total", 32'(begin_count), 32'd6);

    $display("[TB] pointer wraps with simultaneous push and pop");
    doReset();
    out_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (i < 9) begin
        n = 0;
        while (!((fifo_count < 3'(DEPTH - 1)) || (!busy && fifo_count == 3'(DEPTH - 1))) && n < 200) begin
          waitCycles(1);
          n++;
        end
      end
      applyStimulus(randOperand(), randOperand(), randOperand(), 0);
    end
    waitDrain(800);

    $display("[TB] timeout, recovery and early add_ready");
    doReset();
    out_ready = 1'b1;
    checkOutput("sticky_clear", 32'(err_sticky), 32'd0);
    applyStimulus(randOperand(), randOperand(), randOperand(), 1);
    applyStimulus(randOperand(), randOperand(), randOperand(), 0);
    waitDrain(200);
    checkOutput("sticky_set", 32'(err_sticky), 32'd1);
    applyStimulus(randOperand(), randOperand(), randOperand(), 2);
    waitDrain(100);
    checkOutput("sticky_kept", 32'(err_sticky), 32'd1);

    $display("[TB] reset in the middle of WAIT_ADD");
    applyStimulus(c2, c3, c10, 3);
    n = 0;
    while (!pe_begin && n < 20) begin waitCycles(1); n++; end
    checkOutput("midrst_begin_seen", 32'(pe_begin), 32'd1);
    waitCycles(26);
    rst = 1'b1;
    exp_q.delete();
    mode_q.delete();
    waitCycles(1);
    rst = 1'b0;
    accept_idx = 0;
    checkResetState();
    snap_rise = rise_count;
    snap_begin = begin_count;
    waitCycles(40);
    checkOutput("midrst_no_output", 32'(rise_count - snap_rise), 32'd0);
    checkOutput("midrst_no_begin", 32'(begin_count - snap_begin), 32'd0);
    applyStimulus(randOperand(), randOperand(), randOperand(), 0);
    waitDrain(100);

    waitCycles(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
